// File: rtl/irq_pkg.sv
// Shared definitions for the fixed-priority interrupt controller.
//   irq_state_t        : arbitration/service FSM states
//   MCAUSE_IRQ_BIT     : interrupt flag of the RISC-V mcause register
//   DEFAULT_CAUSE_BASE : mcause exception code reported for line 0
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } irq_state_t;

  localparam logic [31:0] MCAUSE_IRQ_BIT     = 32'h8000_0000;
  localparam int          DEFAULT_CAUSE_BASE = 16;

endpackage

// File: rtl/irq_prio_encoder.sv
// Combinational lowest-set-bit priority encoder.
// Ports:
//   req_i    in  N_IRQ  candidate request vector
//   onehot_o out N_IRQ  one-hot of the lowest set bit (0 if none)
//   idx_o    out IDX_W  index of the lowest set bit (0 if none)
//   vld_o    out 1      at least one bit of req_i is set
module irq_prio_encoder #(
  parameter int N_IRQ = 32,
  parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic [N_IRQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
        vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Fixed-priority interrupt controller in front of the RISC-V trap logic.
// Picks the lowest-index enabled pending request, issues a one-cycle trap
// request with its mcause, blocks further interrupts until mret, then sends
// a one-hot completion pulse back to the serviced source.
//
// Optional build macro IRQ_EDGE_DETECT_EN: when defined, requests are
// rising-edge detected into a pending register; otherwise they are level
// sensitive and no extra flops are built.
//
// Ports:
//   clk_i        in  1      system clock, rising edge
//   resetn_i     in  1      asynchronous active-low reset
//   int_req_i    in  N_IRQ  interrupt request lines (synchronous)
//   mie_i        in  N_IRQ  per-line enable mask
//   mie_global_i in  1      global interrupt enable (mstatus.MIE)
//   exception_i  in  1      synchronous exception, defers arbitration
//   irq_ret_i    in  1      mret executed, ends current service
//   irq_o        out 1      one-cycle trap request
//   irq_cause_o  out 32     mcause of the current or last grant
//   int_fin_o    out N_IRQ  one-hot one-cycle completion pulse
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ      = 32,
  parameter int CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             mie_global_i,
  input  logic             exception_i,
  input  logic             irq_ret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] int_fin_o
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       state_q, state_d;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic [N_IRQ-1:0] grant_q;
  logic             arb_en;
  logic             irq_d;
  logic [N_IRQ-1:0] fin_d;
  logic [31:0]      cause_d;

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_IRQ-1:0] req_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] pend_clr;

  // Clear lands on the BUSY->DONE edge; OR-ing the new edge after the
  // clear lets a same-cycle rising edge win.
  assign pend_clr = (state_q == BUSY && irq_ret_i) ? grant_q : '0;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      req_q  <= '0;
      pend_q <= '0;
    end else begin
      req_q  <= int_req_i;
      pend_q <= (pend_q & ~pend_clr) | (int_req_i & ~req_q);
    end
  end

  assign pend = pend_q;
`else
  assign pend = int_req_i;
`endif

  assign eligible = pend & mie_i;

  irq_prio_encoder #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req_i    (eligible),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .vld_o    (win_vld)
  );

  // Arbitration happens only in IDLE; masks and exceptions never touch a
  // grant already taken.
  assign arb_en = (state_q == IDLE) && win_vld && mie_global_i && !exception_i;

  // State register plus registered outputs and grant/cause.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      irq_o       <= 1'b0;
      int_fin_o   <= '0;
      grant_q     <= '0;
      irq_cause_o <= '0;
    end else begin
      state_q   <= state_d;
      irq_o     <= irq_d;
      int_fin_o <= fin_d;
      if (arb_en) begin
        grant_q     <= win_onehot;
        irq_cause_o <= cause_d;
      end else if (state_q == DONE) begin
        grant_q <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_en) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (irq_ret_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: values loaded into the output flops at the next edge.
  // irq_o is high for the cycle following ISSUE; int_fin_o for the DONE cycle.
  always_comb begin
    irq_d   = (state_q == ISSUE);
    fin_d   = (state_q == BUSY && irq_ret_i) ? grant_q : '0;
    cause_d = MCAUSE_IRQ_BIT | (32'(CAUSE_BASE) + 32'(win_idx));
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;

  logic        clk;
  logic        resetn;
  logic [31:0] int_req;
  logic [31:0] mie;
  logic        mie_global;
  logic        exception;
  logic        irq_ret;
  logic        irq;
  logic [31:0] irq_cause;
  logic [31:0] int_fin;

  int checks   = 0;
  int failures = 0;

  irq_priority_ctrl #(
    .N_IRQ      (32),
    .CAUSE_BASE (16)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .int_req_i    (int_req),
    .mie_i        (mie),
    .mie_global_i (mie_global),
    .exception_i  (exception),
    .irq_ret_i    (irq_ret),
    .irq_o        (irq),
    .irq_cause_o  (irq_cause),
    .int_fin_o    (int_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic [31:0] mie;
    logic        glob;
    logic        exc;
    logic        ret;
    logic        exp_irq;
    logic [31:0] exp_cause;
    logic [31:0] exp_fin;
  } vec_t;

  function automatic vec_t mk(logic [31:0] req, logic [31:0] m, logic g, logic e,
                              logic r, logic xi, logic [31:0] xc, logic [31:0] xf);
    vec_t v;
    v.req = req; v.mie = m; v.glob = g; v.exc = e; v.ret = r;
    v.exp_irq = xi; v.exp_cause = xc; v.exp_fin = xf;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, tag, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] req, input logic [31:0] m, input logic g,
                       input logic e, input logic r);
    int_req = req; mie = m; mie_global = g; exception = e; irq_ret = r;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] C10 = 32'h8000_0010;
  localparam logic [31:0] C11 = 32'h8000_0011;
  localparam logic [31:0] C12 = 32'h8000_0012;
  localparam logic [31:0] C13 = 32'h8000_0013;
  localparam logic [31:0] C15 = 32'h8000_0015;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  vec_t tbl[31];

  initial begin
    // Each row: inputs driven, one edge taken, outputs compared.
    tbl[0]  = mk(32'h1,  32'h1, 1, 0, 0, 0, C10, 32'h0);  // IDLE -> ISSUE
    tbl[1]  = mk(32'h1,  32'h1, 1, 0, 0, 1, C10, 32'h0);  // irq pulse
    tbl[2]  = mk(32'h1,  32'h1, 1, 0, 0, 0, C10, 32'h0);
    tbl[3]  = mk(32'h0,  32'h1, 1, 0, 1, 0, C10, 32'h1);  // mret -> fin
    tbl[4]  = mk(32'h0,  32'h1, 1, 0, 0, 0, C10, 32'h0);
    tbl[5]  = mk(32'h0,  32'h1, 1, 0, 0, 0, C10, 32'h0);
    tbl[6]  = mk(32'h24, ALL,   1, 0, 0, 0, C12, 32'h0);  // line 2 wins
    tbl[7]  = mk(32'h24, ALL,   1, 0, 0, 1, C12, 32'h0);
    tbl[8]  = mk(32'h24, ALL,   1, 0, 0, 0, C12, 32'h0);
    tbl[9]  = mk(32'h24, ALL,   1, 0, 1, 0, C12, 32'h4);
    tbl[10] = mk(32'h20, ALL,   1, 0, 0, 0, C12, 32'h0);  // DONE: line 2 drops
    tbl[11] = mk(32'h20, ALL,   1, 0, 0, 0, C15, 32'h0);  // line 5 granted
    tbl[12] = mk(32'h20, ALL,   1, 0, 0, 1, C15, 32'h0);
    tbl[13] = mk(32'h20, ALL,   1, 0, 1, 0, C15, 32'h20);
    tbl[14] = mk(32'h0,  ALL,   1, 0, 0, 0, C15, 32'h0);
    tbl[15] = mk(32'h0,  ALL,   1, 0, 1, 0, C15, 32'h0);  // mret in IDLE ignored
    tbl[16] = mk(32'h1,  32'h1, 1, 1, 0, 0, C15, 32'h0);  // exception defers
    tbl[17] = mk(32'h1,  32'h1, 1, 0, 0, 0, C10, 32'h0);  // retried
    tbl[18] = mk(32'h1,  32'h1, 1, 1, 0, 1, C10, 32'h0);  // exc in ISSUE: no effect
    tbl[19] = mk(32'h0,  32'h0, 0, 0, 1, 0, C10, 32'h1);  // drop+unmask in BUSY
    tbl[20] = mk(32'h0,  32'h0, 0, 0, 0, 0, C10, 32'h0);
    tbl[21] = mk(32'h1,  32'h3, 1, 0, 0, 0, C10, 32'h0);  // busy blocking
    tbl[22] = mk(32'h2,  32'h3, 1, 0, 0, 1, C10, 32'h0);
    tbl[23] = mk(32'h2,  32'h3, 1, 0, 0, 0, C10, 32'h0);
    tbl[24] = mk(32'h2,  32'h3, 1, 0, 0, 0, C10, 32'h0);
    tbl[25] = mk(32'h2,  32'h3, 1, 0, 1, 0, C10, 32'h1);
    tbl[26] = mk(32'h2,  32'h3, 1, 0, 0, 0, C10, 32'h0);  // no arbitration in DONE
    tbl[27] = mk(32'h2,  32'h3, 1, 0, 0, 0, C11, 32'h0);
    tbl[28] = mk(32'h2,  32'h3, 1, 0, 0, 1, C11, 32'h0);
    tbl[29] = mk(32'h2,  32'h3, 1, 0, 1, 0, C11, 32'h2);
    tbl[30] = mk(32'h0,  32'h3, 1, 0, 0, 0, C11, 32'h0);

    apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("reset_irq",   0, 32'(irq), 32'h0);
    chk("reset_cause", 0, irq_cause, 32'h0);
    chk("reset_fin",   0, int_fin,   32'h0);

`ifndef IRQ_EDGE_DETECT_EN
    for (int i = 0; i < 31; i++) begin
      apply(tbl[i].req, tbl[i].mie, tbl[i].glob, tbl[i].exc, tbl[i].ret);
      step();
      chk("tbl_irq",   i, 32'(irq), 32'(tbl[i].exp_irq));
      chk("tbl_cause", i, irq_cause, tbl[i].exp_cause);
      chk("tbl_fin",   i, int_fin,   tbl[i].exp_fin);
    end

    // Masked by mie_i for 20 cycles.
    apply(32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mask_line_irq", i, 32'(irq), 32'h0);
    end
    apply(32'h8, 32'h8, 1'b1, 1'b0, 1'b0);
    step();
    chk("unmask_cause", 0, irq_cause, C13);
    chk("unmask_irq0",  0, 32'(irq), 32'h0);
    step();
    chk("unmask_irq1",  1, 32'(irq), 32'h1);
    apply(32'h0, 32'h8, 1'b1, 1'b0, 1'b1);
    step();
    chk("unmask_fin",   0, int_fin, 32'h8);
    apply(32'h0, 32'h8, 1'b1, 1'b0, 1'b0);
    step();

    // Masked by mie_global_i for 20 cycles.
    apply(32'h8, 32'h8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mask_global_irq", i, 32'(irq), 32'h0);
    end
    chk("mask_global_cause", 0, irq_cause, C13);

    // Reset asserted mid-service.
    apply(32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_mid_cause", 0, irq_cause, C10);
    step();
    chk("rst_mid_irq", 0, 32'(irq), 32'h1);
    step();
    resetn = 1'b0;
    irq_ret = 1'b1;
    #1;
    chk("rst_async_irq",   0, 32'(irq), 32'h0);
    chk("rst_async_cause", 0, irq_cause, 32'h0);
    chk("rst_async_fin",   0, int_fin,   32'h0);
    step();
    chk("rst_hold_fin", 0, int_fin, 32'h0);
    resetn = 1'b1;
    irq_ret = 1'b0;
    step();
    chk("rst_regrant_cause", 0, irq_cause, C10);
    chk("rst_regrant_irq0",  0, 32'(irq), 32'h0);
    step();
    chk("rst_regrant_irq1",  1, 32'(irq), 32'h1);
`else
    // One-cycle pulse on masked line 3 must stay pending.
    apply(32'h8, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    apply(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("edge_masked_irq", i, 32'(irq), 32'h0);
    end
    apply(32'h0, 32'h8, 1'b1, 1'b0, 1'b0);
    step();
    chk("edge_cause", 0, irq_cause, C13);
    step();
    chk("edge_irq", 0, 32'(irq), 32'h1);
    apply(32'h0, 32'h8, 1'b1, 1'b0, 1'b1);
    step();
    chk("edge_fin", 0, int_fin, 32'h8);
    apply(32'h0, 32'h8, 1'b1, 1'b0, 1'b0);
    step();
    chk("edge_fin_end", 0, int_fin, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("edge_cleared_irq", i, 32'(irq), 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
